// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// opcode field geometry and the output-register source select.
package inst_fetch_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_INST_W = 16;

    // Opcode occupies the top OPC_W bits of every instruction word.
    localparam int OPC_W = 4;

    // Where the if_* register takes its next value from, in priority order.
    typedef enum logic [2:0] {
        SEL_FLUSH  = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_SKID   = 3'd2,
        SEL_MEM    = 3'd3,
        SEL_BUBBLE = 3'd4
    } out_sel_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a {inst, pc} pair that arrived while decode
// was stalled. clear wins over push so a redirect always drops the entry.
module fetch_skid #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    logic [W-1:0] data_q;
    logic         full_q;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (push) begin
            full_q <= 1'b1;
            data_q <= din;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a synchronous
// instruction memory and presents one registered instruction per cycle to
// decode. Stalls are absorbed by a one-entry skid; redirects flush.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [OPC_W-1:0]  if_opcode
);

    localparam int SKID_W = INST_W + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;

    out_sel_e          out_sel;

    logic              skid_push;
    logic              skid_pop;
    logic              skid_clear;
    logic [SKID_W-1:0] skid_dout;
    logic              skid_full;

    // A redirect fetches even under stall so the target is in flight as
    // soon as possible; the stale held instruction is dropped anyway.
    assign imem_en   = !rst && (redirect || !stall);
    assign imem_addr = redirect ? redirect_pc : pc;

    // Pick the source for the output register, highest priority first.
    always_comb begin
        out_sel = SEL_BUBBLE;
        if (redirect)
            out_sel = SEL_FLUSH;
        else if (stall)
            out_sel = SEL_HOLD;
        else if (skid_full)
            out_sel = SEL_SKID;
        else if (inflight)
            out_sel = SEL_MEM;
    end

    assign skid_push  = !rst && (out_sel == SEL_HOLD) && inflight;
    assign skid_pop   = !rst && (out_sel == SEL_SKID);
    assign skid_clear = !rst && redirect;

    fetch_skid #(
        .W (SKID_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push),
        .pop   (skid_pop),
        .clear (skid_clear),
        .din   ({imem_rdata, req_pc}),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    // PC advance and tracking of the request whose data lands next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (imem_en) begin
            pc       <= imem_addr + ADDR_W'(1);
            req_pc   <= imem_addr;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Output register toward decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_inst  <= '0;
            if_pc    <= '0;
        end else begin
            case (out_sel)
                SEL_HOLD: ;
                SEL_SKID: begin
                    if_valid <= 1'b1;
                    if_inst  <= skid_dout[SKID_W-1:ADDR_W];
                    if_pc    <= skid_dout[ADDR_W-1:0];
                end
                SEL_MEM: begin
                    if_valid <= 1'b1;
                    if_inst  <= imem_rdata;
                    if_pc    <= req_pc;
                end
                default: begin
                    if_valid <= 1'b0;
                    if_inst  <= '0;
                end
            endcase
        end
    end

    // The skid only drains in a cycle with nothing issued the cycle before,
    // so a skid entry and a fresh response can never compete.
    always_ff @(posedge clk) begin
        if (!rst && !redirect && !stall)
            assert (!(skid_full && inflight));
    end

    assign if_opcode = if_inst[INST_W-1 -: OPC_W];

endmodule
